mil1553_word_gen: RTL and testbench

- Synthesizable MIL-STD-1553 word transmitter that replaces the fixed-pattern bench stimulus.
- Accepts 16-bit words with per-word control through a valid/ready stream and buffers them in a small FIFO.
- Serialises each word as Manchester II: 3-bit sync, 16 data bits MSB first, 1 odd-parity bit.
- Drives the differential tx pair and transceiver enable; provides configurable inter-word gap, contiguous-message mode, and parity/Manchester error injection for receiver verification.

---
 rtl/mil1553_word_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_mil1553_word_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mil1553_word_gen.sv
// MIL-STD-1553 word transmitter.
// Buffers 16-bit words from a valid/ready stream in a small FIFO and serialises
// each one as Manchester II: 3-bit-time sync, 16 data bits MSB first, odd parity.
// Ports:
//   aclk, arst        - clock, asynchronous active-high reset
//   s_tdata[15:0]     - word, bit 15 sent first
//   s_tuser[2:0]      - [0] command/status sync, [1] parity error, [2] Manchester error
//   s_tvalid/s_tready - input handshake (s_tready = FIFO not full, registered)
//   tx0_1553/tx1_1553 - differential line pair (00 when idle)
//   en_diff           - transceiver enable
//   busy              - transmitting, in gap, or FIFO holds words
//   words_sent[15:0]  - completed-word counter, wraps
module mil1553_word_gen #(
  parameter int unsigned CLOCK_SPEED = 50000000,
  parameter int unsigned BIT_RATE    = 1000000,
  parameter int unsigned GAP_BITS    = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          INVERT_DATA = 1'b0
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_tdata,
  input  logic [2:0]  s_tuser,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        tx0_1553,
  output logic        tx1_1553,
  output logic        en_diff,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int unsigned CPB       = CLOCK_SPEED / BIT_RATE;
  localparam int unsigned HALF      = CPB / 2;
  localparam int unsigned SYNC_LEN  = 3 * CPB;
  localparam int unsigned SYNC_HALF = SYNC_LEN / 2;
  localparam int unsigned GAP_LEN   = GAP_BITS * CPB;
  localparam int unsigned GAP_LAST  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
  localparam int unsigned CYC_W     = $clog2(SYNC_LEN);
  localparam int unsigned GAP_W     = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENT_W     = 19;

  if ((CPB < 4) || ((CPB % 2) != 0)) begin : g_bad_cpb
    $error("mil1553_word_gen: CLOCK_SPEED/BIT_RATE must be even and >= 4");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mil1553_word_gen: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  // FIFO storage and pointers
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_n;
  logic             push, pop, empty;
  logic [ENT_W-1:0] head;

  // FSM and datapath registers
  logic [2:0]       state_q, state_n;
  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic [3:0]       bit_q, bit_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [15:0]      data_q, data_n;
  logic [2:0]       user_q, user_n;
  logic             par_q, par_n;
  logic [15:0]      words_q, words_n;
  logic             load, active, level, cur_bit;

  assign push  = s_tvalid & s_tready;
  assign empty = (count_q == '0);
  assign head  = mem[rd_q];

  // Next state, counters and the line level that goes with the next state
  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    data_n  = data_q;
    user_n  = user_q;
    par_n   = par_q;
    words_n = words_q;
    load    = 1'b0;
    pop     = 1'b0;
    active  = 1'b0;
    level   = 1'b0;
    cur_bit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) load = 1'b1;
      end
      ST_SYNC: begin
        if (cyc_q == CYC_W'(SYNC_LEN - 1)) begin
          state_n = ST_DATA;
          cyc_n   = '0;
          bit_n   = 4'd15;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_DATA: begin
        if (cyc_q == CYC_W'(CPB - 1)) begin
          cyc_n = '0;
          if (bit_q == 4'd0) state_n = ST_PARITY;
          else               bit_n   = bit_q - 4'd1;
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_PARITY: begin
        if (cyc_q == CYC_W'(CPB - 1)) begin
          words_n = words_q + 16'd1;
          if (GAP_LEN > 0) begin
            state_n = ST_GAP;
            gap_n   = '0;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      ST_GAP: begin
        // A waiting word is popped on the last gap cycle so the idle line lasts
        // exactly GAP_BITS bit-times between words.
        if (gap_q == GAP_W'(GAP_LAST)) begin
          if (!empty) load = 1'b1;
          else        state_n = ST_IDLE;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Pop the FIFO head and start its sync
    if (load) begin
      pop     = 1'b1;
      state_n = ST_SYNC;
      cyc_n   = '0;
      data_n  = head[15:0];
      user_n  = head[18:16];
      par_n   = (~^head[15:0]) ^ head[17];
    end

    // tx0 level: a one is low-then-high, a zero is high-then-low
    case (state_n)
      ST_SYNC: begin
        active = 1'b1;
        level  = (cyc_n < CYC_W'(SYNC_HALF)) ? ~user_n[0] : user_n[0];
      end
      ST_DATA: begin
        active  = 1'b1;
        cur_bit = data_n[bit_n];
        // Manchester error: bit 15 keeps its first-half level for the whole bit
        if ((cyc_n < CYC_W'(HALF)) || (user_n[2] && (bit_n == 4'd15))) level = ~cur_bit;
        else                                                            level = cur_bit;
      end
      ST_PARITY: begin
        active  = 1'b1;
        cur_bit = par_n;
        level   = (cyc_n < CYC_W'(HALF)) ? ~cur_bit : cur_bit;
      end
      default: ;
    endcase

    count_n = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO write port
  always_ff @(posedge aclk) begin
    if (push) mem[wr_q] <= {s_tuser, s_tdata};
  end

  // State, counters and registered outputs
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      user_q     <= '0;
      par_q      <= 1'b0;
      words_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      s_tready   <= 1'b0;
      tx0_1553   <= 1'b0;
      tx1_1553   <= 1'b0;
      en_diff    <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
    end else begin
      state_q    <= state_n;
      cyc_q      <= cyc_n;
      bit_q      <= bit_n;
      gap_q      <= gap_n;
      data_q     <= data_n;
      user_q     <= user_n;
      par_q      <= par_n;
      words_q    <= words_n;
      count_q    <= count_n;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      s_tready   <= (count_n != CNT_W'(FIFO_DEPTH));
      busy       <= (state_n != ST_IDLE) || (count_n != '0);
      tx0_1553   <= active & (level ^ INVERT_DATA);
      tx1_1553   <= active & ~(level ^ INVERT_DATA);
      en_diff    <= active;
      words_sent <= words_n;
    end
  end

endmodule

// File: tb/tb_mil1553_word_gen.sv
// Bench for mil1553_word_gen: dut_a (gap 4 bit-times), dut_b (contiguous, inverted).
module tb_mil1553_word_gen;

  localparam int CPB      = 50;
  localparam int HALF_CYC = CPB / 2;
  localparam int WORD_CYC = 20 * CPB;
  localparam int CAP      = 32;
  localparam logic [1:0] INV = 2'b10;

  logic aclk = 1'b0;
  logic arst;
  always #10 aclk = ~aclk;

  logic [15:0] a_tdata, b_tdata, a_sent, b_sent;
  logic [2:0]  a_tuser, b_tuser;
  logic a_tvalid, b_tvalid, a_tready, b_tready;
  logic a_tx0, a_tx1, a_en, a_busy, b_tx0, b_tx1, b_en, b_busy;

  mil1553_word_gen #(.CLOCK_SPEED(50000000), .BIT_RATE(1000000), .GAP_BITS(4),
                     .FIFO_DEPTH(4), .INVERT_DATA(1'b0)) dut_a (
    .aclk(aclk), .arst(arst), .s_tdata(a_tdata), .s_tuser(a_tuser),
    .s_tvalid(a_tvalid), .s_tready(a_tready), .tx0_1553(a_tx0), .tx1_1553(a_tx1),
    .en_diff(a_en), .busy(a_busy), .words_sent(a_sent));

  mil1553_word_gen #(.CLOCK_SPEED(50000000), .BIT_RATE(1000000), .GAP_BITS(0),
                     .FIFO_DEPTH(4), .INVERT_DATA(1'b1)) dut_b (
    .aclk(aclk), .arst(arst), .s_tdata(b_tdata), .s_tuser(b_tuser),
    .s_tvalid(b_tvalid), .s_tready(b_tready), .tx0_1553(b_tx0), .tx1_1553(b_tx1),
    .en_diff(b_en), .busy(b_busy), .words_sent(b_sent));

  logic [1:0] en_w, tx0_w, tx1_w, busy_w;
  assign en_w   = {b_en, a_en};
  assign tx0_w  = {b_tx0, a_tx0};
  assign tx1_w  = {b_tx1, a_tx1};
  assign busy_w = {b_busy, a_busy};

  // Monitor state: captured word waveforms (tx0 level, inversion undone) and run lengths
  logic [WORD_CYC-1:0] acc [2];
  logic [WORD_CYC-1:0] cap [2][CAP];
  int cap_n[2], acc_n[2], hi_run[2], lo_run[2], hi_n[2], lo_n[2], viol[2], frag[2];
  int hi_len[2][CAP], lo_len[2][CAP];
  bit had_hi[2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: 40 half-bit slots; 0..5 sync, then (bit, parity) pairs
  function automatic logic [WORD_CYC-1:0] model_wave(input logic [15:0] d, input logic [2:0] u);
    logic [WORD_CYC-1:0] w;
    logic b, par;
    int h, i;
    par = (($countones(d) % 2) == 0) ^ u[1];
    for (int t = 0; t < WORD_CYC; t++) begin
      h = t / HALF_CYC;
      if (h < 6) begin
        w[t] = u[0] ? (h >= 3) : (h < 3);
      end else begin
        i = (h - 6) / 2;
        b = (i == 16) ? par : d[4'(15 - i)];
        if (((h % 2) == 0) || ((i == 0) && u[2])) w[t] = ~b;
        else                                      w[t] = b;
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic check_wave(input string tag, input int k, input int idx,
                            input logic [15:0] d, input logic [2:0] u);
    logic [WORD_CYC-1:0] exp_w, obs_w;
    int first;
    exp_w = model_wave(d, u);
    obs_w = (idx < cap_n[k]) ? cap[k][idx % CAP] : '0;
    first = 0;
    for (int t = WORD_CYC - 1; t >= 0; t--) if (obs_w[t] !== exp_w[t]) first = t;
    n_checks++;
    assert (obs_w === exp_w) n_pass++;
    else $error("FAIL %s: word %0d (data %h user %b) cycle %0d observed %b required %b",
                tag, idx, d, u, first, obs_w[first], exp_w[first]);
  endtask

  task automatic push(input int k, input logic [15:0] d, input logic [2:0] u);
    int g = 0;
    if (k == 0) begin a_tdata = d; a_tuser = u; a_tvalid = 1'b1; end
    else        begin b_tdata = d; b_tuser = u; b_tvalid = 1'b1; end
    while (((k == 0) ? !a_tready : !b_tready) && (g < 5000)) begin
      @(negedge aclk); g++;
    end
    check("push_ready", 32'(g < 5000), 32'd1);
    @(negedge aclk);
    if (k == 0) a_tvalid = 1'b0; else b_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget, input string tag);
    int g = 0;
    while (busy_w[k] && (g < budget)) begin @(negedge aclk); g++; end
    check(tag, 32'(g < budget), 32'd1);
  endtask

  // Line monitor, sampled on the falling edge
  initial begin
    for (int k = 0; k < 2; k++) begin
      acc[k] = '0; cap_n[k] = 0; acc_n[k] = 0; hi_run[k] = 0; lo_run[k] = 0;
      hi_n[k] = 0; lo_n[k] = 0; viol[k] = 0; frag[k] = 0; had_hi[k] = 0;
    end
    forever begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        if (arst) begin
          acc_n[k] = 0; hi_run[k] = 0; lo_run[k] = 0; had_hi[k] = 0;
        end else if (en_w[k]) begin
          if (tx1_w[k] !== ~tx0_w[k]) viol[k]++;
          if ((hi_run[k] == 0) && had_hi[k]) begin
            lo_len[k][lo_n[k] % CAP] = lo_run[k]; lo_n[k]++;
          end
          hi_run[k]++;
          acc[k][acc_n[k]] = tx0_w[k] ^ INV[k];
          acc_n[k]++;
          if (acc_n[k] == WORD_CYC) begin
            cap[k][cap_n[k] % CAP] = acc[k]; cap_n[k]++; acc_n[k] = 0;
          end
        end else begin
          if ((tx0_w[k] !== 1'b0) || (tx1_w[k] !== 1'b0)) viol[k]++;
          if (hi_run[k] > 0) begin
            hi_len[k][hi_n[k] % CAP] = hi_run[k]; hi_n[k]++;
            hi_run[k] = 0; lo_run[k] = 0; had_hi[k] = 1;
          end
          lo_run[k]++;
          if (acc_n[k] != 0) begin frag[k]++; acc_n[k] = 0; end
        end
      end
    end
  end

  logic [15:0] wd [10];
  logic [2:0]  wu [10];
  int base, hb, lb, g, n_acc, stall_at;
  logic [15:0] exp_a;

  initial begin
    arst = 1'b1;
    a_tdata = '0; a_tuser = '0; a_tvalid = 1'b0;
    b_tdata = '0; b_tuser = '0; b_tvalid = 1'b0;
    exp_a = 16'd0;

    // Reset held for 1 us (50 cycles)
    repeat (50) @(negedge aclk);
    check("rst_tx", 32'({a_tx0, a_tx1, b_tx0, b_tx1}), 32'd0);
    check("rst_en", 32'({a_en, b_en}), 32'd0);
    check("rst_ready", 32'({a_tready, b_tready}), 32'd0);
    check("rst_busy", 32'({a_busy, b_busy}), 32'd0);
    arst = 1'b0;
    @(negedge aclk);
    check("idle_ready", 32'({a_tready, b_tready}), 32'b11);
    check("idle_busy", 32'({a_busy, b_busy}), 32'd0);
    check("idle_line", 32'({a_tx0, a_tx1, a_en}), 32'd0);
    check("idle_sent", 32'(a_sent), 32'd0);

    // Single command word
    base = cap_n[0]; hb = hi_n[0];
    push(0, 16'hFFFF, 3'b001);
    wait_idle(0, 3000, "t1_idle");
    exp_a = exp_a + 16'd1;
    check("t1_words", 32'(cap_n[0] - base), 32'd1);
    check_wave("t1_wave", 0, base, 16'hFFFF, 3'b001);
    check("t1_en_len", 32'(hi_len[0][hb % CAP]), 32'd1000);
    check("t1_sent", 32'(a_sent), 32'(exp_a));

    // Two data words with gap
    base = cap_n[0]; lb = lo_n[0];
    push(0, 16'h0001, 3'b000);
    push(0, 16'h0000, 3'b000);
    wait_idle(0, 5000, "t2_idle");
    exp_a = exp_a + 16'd2;
    check("t2_words", 32'(cap_n[0] - base), 32'd2);
    check_wave("t2_wave0", 0, base, 16'h0001, 3'b000);
    check_wave("t2_wave1", 0, base + 1, 16'h0000, 3'b000);
    check("t2_gaps", 32'(lo_n[0] - lb), 32'd2);
    check("t2_gap_len", 32'(lo_len[0][(lo_n[0] - 1) % CAP]), 32'd200);
    check("t2_sent", 32'(a_sent), 32'(exp_a));

    // Contiguous message on dut_b, random words
    base = cap_n[1]; hb = hi_n[1];
    for (int i = 0; i < 3; i++) begin
      wd[i] = 16'($urandom); wu[i] = 3'($urandom_range(0, 7));
    end
    for (int i = 0; i < 3; i++) push(1, wd[i], wu[i]);
    wait_idle(1, 6000, "t3_idle");
    check("t3_words", 32'(cap_n[1] - base), 32'd3);
    check("t3_en_runs", 32'(hi_n[1] - hb), 32'd1);
    check("t3_en_len", 32'(hi_len[1][hb % CAP]), 32'd3000);
    for (int i = 0; i < 3; i++) check_wave("t3_wave", 1, base + i, wd[i], wu[i]);
    check("t3_sent", 32'(b_sent), 32'd3);

    // Backpressure: valid held for 10 random words
    base = cap_n[0];
    for (int i = 0; i < 10; i++) begin
      wd[i] = 16'($urandom); wu[i] = 3'($urandom_range(0, 7));
    end
    n_acc = 0; stall_at = -1; g = 0;
    a_tdata = wd[0]; a_tuser = wu[0]; a_tvalid = 1'b1;
    while ((n_acc < 10) && (g < 20000)) begin
      if (a_tready) begin
        @(negedge aclk);
        n_acc++;
        if (n_acc < 10) begin a_tdata = wd[n_acc]; a_tuser = wu[n_acc]; end
      end else begin
        if (stall_at < 0) stall_at = n_acc;
        @(negedge aclk);
      end
      g++;
    end
    a_tvalid = 1'b0;
    check("bp_accepted", 32'(n_acc), 32'd10);
    check("bp_stall_at", 32'(stall_at), 32'd5);
    wait_idle(0, 20000, "bp_idle");
    exp_a = exp_a + 16'd10;
    check("bp_words", 32'(cap_n[0] - base), 32'd10);
    for (int i = 0; i < 10; i++) check_wave("bp_wave", 0, base + i, wd[i], wu[i]);
    check("bp_gap_len", 32'(lo_len[0][(lo_n[0] - 1) % CAP]), 32'd200);
    check("bp_sent", 32'(a_sent), 32'(exp_a));
    check("frag_a", 32'(frag[0]), 32'd0);

    // Error injection: Manchester error on bit 15 plus inverted parity
    base = cap_n[0];
    push(0, 16'h8000, 3'b110);
    wait_idle(0, 3000, "err_idle");
    exp_a = exp_a + 16'd1;
    check_wave("err_wave", 0, base, 16'h8000, 3'b110);
    check("err_bit15_flat", 32'(cap[0][base % CAP][199:150]), 32'd0);
    check("err_sent", 32'(a_sent), 32'(exp_a));

    // Reset 500 cycles into the next word
    base = cap_n[0]; hb = hi_n[0];
    push(0, 16'($urandom), 3'b001);
    g = 0;
    while (!a_en && (g < 100)) begin @(negedge aclk); g++; end
    check("rst_word_started", 32'(g < 100), 32'd1);
    repeat (500) @(negedge aclk);
    #3 arst = 1'b1;
    #1;
    check("arst_line", 32'({a_tx0, a_tx1, a_en}), 32'd0);
    check("arst_sent", 32'(a_sent), 32'd0);
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_ready", 32'(a_tready), 32'd0);
    repeat (3) @(negedge aclk);
    arst = 1'b0;
    repeat (2) @(negedge aclk);
    check("post_rst_ready", 32'(a_tready), 32'd1);
    repeat (1500) @(negedge aclk);
    check("post_rst_busy", 32'(a_busy), 32'd0);
    check("post_rst_no_word", 32'(cap_n[0] - base), 32'd0);
    check("post_rst_no_en", 32'(hi_n[0] - hb), 32'd0);
    check("post_rst_sent", 32'({a_sent, b_sent}), 32'd0);

    check("line_viol_a", 32'(viol[0]), 32'd0);
    check("line_viol_b", 32'(viol[1]), 32'd0);
    check("frag_b", 32'(frag[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
